// File: rtl/switch_reader_pkg.sv
// Shared constants and types for the ten-switch debounced reader.
// The default debounce window is 10 ms at a 100 MHz system clock.
package switch_reader_pkg;

  localparam int NUM_SW                  = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam logic [NUM_SW-1:0] MATCH_CODE_DEFAULT = 10'h3C2;

  typedef logic [NUM_SW-1:0] sw_vec_t;

  // The counter must be able to represent DEBOUNCE_CYCLES without wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch lane: 2-flop synchronizer, consecutive-difference counter and
// the accepted (stable) level.
module sw_debounce_bit
  import switch_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic sw,
  output logic stable
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_reader.sv
// Debounced ten-switch reader with a valid/ready change-event port, a
// registered pattern match flag and a sticky overrun flag.
module switch_reader
  import switch_reader_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [NUM_SW-1:0] MATCH_CODE     = MATCH_CODE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sw1,
  input  logic              sw2,
  input  logic              sw3,
  input  logic              sw4,
  input  logic              sw5,
  input  logic              sw6,
  input  logic              sw7,
  input  logic              sw8,
  input  logic              sw9,
  input  logic              sw10,
  output logic [NUM_SW-1:0] sw_stable,
  output logic              evt_valid,
  output logic [NUM_SW-1:0] evt_data,
  input  logic              evt_ready,
  output logic              match,
  output logic              overrun
);

  sw_vec_t raw_vec;
  wire sw_vec_t stable_vec;
  sw_vec_t stable_q;
  logic    changed;
  logic    transfer;

  assign raw_vec = {sw10, sw9, sw8, sw7, sw6, sw5, sw4, sw3, sw2, sw1};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_lane
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .sw    (raw_vec[i]),
      .stable(stable_vec[i])
    );
  end

  assign sw_stable = stable_vec;

  // Any number of bits flipping together shows up as a single vector change.
  assign changed  = (stable_vec != stable_q);
  assign transfer = evt_valid & evt_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q  <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
      match     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      stable_q <= stable_vec;
      match    <= (stable_vec == MATCH_CODE);
      if (changed) begin
        // A change that coincides with a transfer replaces, not overwrites.
        if (evt_valid && !evt_ready) begin
          overrun <= 1'b1;
        end
        evt_valid <= 1'b1;
        evt_data  <= stable_vec;
      end else if (transfer) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
